// File: rtl/rtc_arb_pkg.sv
// rtc_arb_pkg: state encoding, requester indices and default widths for the RTC bus arbiter
package rtc_arb_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, RELEASE} state_t;
  localparam int REQ_INIT    = 0;
  localparam int REQ_WRITE   = 1;
  localparam int REQ_CRONO   = 2;
  localparam int REQ_READ    = 3;
  localparam int NREQ_DEF    = 4;
  localparam int AW_DEF      = 8;
  localparam int DW_DEF      = 8;
  localparam int TIMEOUT_DEF = 128;
endpackage

// File: rtl/rtc_bus_arbiter_if.sv
// rtc_bus_arbiter_if: requester-side and protocol-engine-side signals of the RTC bus arbiter
interface rtc_bus_arbiter_if
  import rtc_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
);
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_rnw;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    ack;
  logic [DW-1:0]      rdata;
  logic               busy;
  logic               err;
  logic               rtc_start;
  logic [AW-1:0]      rtc_addr;
  logic [DW-1:0]      rtc_wdata;
  logic               rtc_rnw;
  logic               rtc_done;
  logic [DW-1:0]      rtc_rdata;
  modport master (
    output req, req_addr, req_wdata, req_rnw, rtc_done, rtc_rdata,
    input  gnt, ack, rdata, busy, err, rtc_start, rtc_addr, rtc_wdata, rtc_rnw
  );
  modport slave (
    input  req, req_addr, req_wdata, req_rnw, rtc_done, rtc_rdata,
    output gnt, ack, rdata, busy, err, rtc_start, rtc_addr, rtc_wdata, rtc_rnw
  );
endinterface

// File: rtl/rtc_arb_prio_enc.sv
// rtc_arb_prio_enc: fixed-priority encoder, lowest set index wins -> one-hot, index, valid
module rtc_arb_prio_enc #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  output logic [NREQ-1:0] o_onehot,
  output logic [IW-1:0]   o_idx,
  output logic            o_valid
);
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (i_req[k]) begin
        o_onehot    = '0;
        o_onehot[k] = 1'b1;
        o_idx       = IW'(k);
      end
    end
    o_valid = |i_req;
  end
endmodule

// File: rtl/rtc_bus_arbiter.sv
// rtc_bus_arbiter: shares one RTC protocol engine among NREQ requesters, one transaction at a time.
// Optional BUSY-state timeout enabled by defining RTC_ARB_TIMEOUT_EN.
module rtc_bus_arbiter
  import rtc_arb_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic           clk,
  input  logic           reset,
  rtc_bus_arbiter_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  if (TIMEOUT < 2) begin : g_to_chk
    $error("rtc_bus_arbiter: TIMEOUT must be at least 2");
  end
  state_t          r_state, w_next;
  logic [NREQ-1:0] r_sel, w_onehot;
  logic [IW-1:0]   w_idx;
  logic            w_valid, w_active, w_to;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata, r_rdata;
  logic            r_rnw;
  rtc_arb_prio_enc #(.NREQ(NREQ), .IW(IW)) u_enc (
    .i_req   (bus.req),
    .o_onehot(w_onehot),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );
  assign w_active = (r_state == LAUNCH) || (r_state == BUSY);
`ifdef RTC_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] r_cnt;
  logic          r_err;
  assign w_to = (r_state == BUSY) && !bus.rtc_done && (r_cnt == CW'(TIMEOUT - 1));
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= (r_state == BUSY) ? r_cnt + 1'b1 : '0;
      r_err <= w_to;
    end
  end
  assign bus.err = (r_state == RELEASE) && r_err;
`else
  assign w_to    = 1'b0;
  assign bus.err = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_valid ? LAUNCH : IDLE;
      LAUNCH:  w_next = BUSY;
      BUSY:    w_next = (bus.rtc_done || w_to) ? RELEASE : BUSY;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rnw   <= 1'b1;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_valid) begin
        r_sel   <= w_onehot;
        r_addr  <= bus.req_addr[w_idx*AW +: AW];
        r_wdata <= bus.req_wdata[w_idx*DW +: DW];
        r_rnw   <= bus.req_rnw[w_idx];
      end
      if (r_state == BUSY && bus.rtc_done && r_rnw) r_rdata <= bus.rtc_rdata;
    end
  end
  assign bus.gnt       = w_active ? r_sel : '0;
  assign bus.ack       = (r_state == RELEASE) ? r_sel : '0;
  assign bus.busy      = r_state != IDLE;
  assign bus.rtc_start = r_state == LAUNCH;
  assign bus.rtc_addr  = r_addr;
  assign bus.rtc_wdata = w_active ? r_wdata : '0;
  assign bus.rtc_rnw   = w_active ? r_rnw : 1'b1;
  assign bus.rdata     = r_rdata;
endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// tb_rtc_bus_arbiter: directed self-checking bench for rtc_bus_arbiter
module tb_rtc_bus_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  rtc_bus_arbiter_if #(.NREQ(4), .AW(8), .DW(8)) bus ();
`ifdef RTC_ARB_TIMEOUT_EN
  rtc_bus_arbiter #(.NREQ(4), .AW(8), .DW(8), .TIMEOUT(8)) dut (
`else
  rtc_bus_arbiter #(.NREQ(4), .AW(8), .DW(8)) dut (
`endif
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    bus.req = '0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_rnw = '0;
    bus.rtc_done = 1'b0; bus.rtc_rdata = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_ack", bus.ack, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_start", bus.rtc_start, 0);
    chk("rst_addr", bus.rtc_addr, 0);
    chk("rst_wdata", bus.rtc_wdata, 0);
    chk("rst_rnw", bus.rtc_rnw, 1);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_err", bus.err, 0);
    // read by requester 3, done three cycles after start
    bus.req = 4'b1000; bus.req_addr[3*8 +: 8] = 8'h21; bus.req_rnw[3] = 1'b1;
    tick();
    chk("t1_start", bus.rtc_start, 1);
    chk("t1_gnt", bus.gnt, 4'b1000);
    chk("t1_busy", bus.busy, 1);
    chk("t1_addr", bus.rtc_addr, 8'h21);
    chk("t1_rnw", bus.rtc_rnw, 1);
    bus.req = 4'b0000;
    tick();
    chk("t1_start_off", bus.rtc_start, 0);
    chk("t1_gnt_held", bus.gnt, 4'b1000);
    tick(); tick();
    bus.rtc_done = 1'b1; bus.rtc_rdata = 8'h45;
    tick();
    bus.rtc_done = 1'b0;
    chk("t1_ack", bus.ack, 4'b1000);
    chk("t1_rdata", bus.rdata, 8'h45);
    chk("t1_rel_gnt", bus.gnt, 0);
    chk("t1_rel_busy", bus.busy, 1);
    chk("t1_rel_err", bus.err, 0);
    tick();
    chk("t1_idle_ack", bus.ack, 0);
    chk("t1_idle_busy", bus.busy, 0);
    // simultaneous write (1) and crono (2)
    bus.req = 4'b0110;
    bus.req_addr[1*8 +: 8] = 8'h11; bus.req_wdata[1*8 +: 8] = 8'hA5; bus.req_rnw[1] = 1'b0;
    bus.req_addr[2*8 +: 8] = 8'h12; bus.req_wdata[2*8 +: 8] = 8'h5A; bus.req_rnw[2] = 1'b0;
    tick();
    chk("t2_gnt1", bus.gnt, 4'b0010);
    chk("t2_wdata1", bus.rtc_wdata, 8'hA5);
    chk("t2_rnw1", bus.rtc_rnw, 0);
    tick();
    bus.rtc_done = 1'b1;
    tick();
    bus.rtc_done = 1'b0;
    chk("t2_ack1", bus.ack, 4'b0010);
    chk("t2_rel_rnw", bus.rtc_rnw, 1);
    chk("t2_rel_wdata", bus.rtc_wdata, 0);
    bus.req = 4'b0100;
    tick();
    chk("t2_gap_start", bus.rtc_start, 0);
    chk("t2_gap_gnt", bus.gnt, 0);
    tick();
    chk("t2_gnt2", bus.gnt, 4'b0100);
    chk("t2_addr2", bus.rtc_addr, 8'h12);
    chk("t2_wdata2", bus.rtc_wdata, 8'h5A);
    bus.req = 4'b0000;
    tick();
    bus.rtc_done = 1'b1; bus.rtc_rdata = 8'hEE;
    tick();
    bus.rtc_done = 1'b0;
    chk("t2_ack2", bus.ack, 4'b0100);
    chk("t2_rdata_keep", bus.rdata, 8'h45);
    tick();
    // init write held high through the transaction
    bus.req = 4'b0001; bus.req_addr[7:0] = 8'h02; bus.req_wdata[7:0] = 8'h10; bus.req_rnw[0] = 1'b0;
    tick();
    chk("t3_start", bus.rtc_start, 1);
    chk("t3_rnw", bus.rtc_rnw, 0);
    chk("t3_addr", bus.rtc_addr, 8'h02);
    chk("t3_wdata", bus.rtc_wdata, 8'h10);
    tick();
    chk("t3_start_once", bus.rtc_start, 0);
    bus.rtc_done = 1'b1; bus.rtc_rdata = 8'h33;
    tick();
    bus.rtc_done = 1'b0;
    chk("t3_ack", bus.ack, 4'b0001);
    chk("t3_rdata_keep", bus.rdata, 8'h45);
    bus.req = 4'b0000;
    tick();
    // reset while BUSY abandons the transaction
    bus.req = 4'b1000; bus.req_addr[3*8 +: 8] = 8'h33;
    tick();
    bus.req = 4'b0000;
    tick();
    chk("t4_busy_pre", bus.busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t4_gnt", bus.gnt, 0);
    chk("t4_busy", bus.busy, 0);
    chk("t4_rnw", bus.rtc_rnw, 1);
    chk("t4_ack", bus.ack, 0);
    chk("t4_addr", bus.rtc_addr, 0);
    chk("t4_rdata", bus.rdata, 0);
    bus.rtc_done = 1'b1; bus.rtc_rdata = 8'h99;
    tick();
    bus.rtc_done = 1'b0;
    chk("t4_late_ack", bus.ack, 0);
    chk("t4_late_busy", bus.busy, 0);
    chk("t4_late_rdata", bus.rdata, 0);
    tick();
    chk("t4_no_restart", bus.rtc_start, 0);
    // requester drops req and changes addr mid-transaction
    bus.req = 4'b0010; bus.req_addr[1*8 +: 8] = 8'h44; bus.req_rnw[1] = 1'b1;
    tick();
    bus.req = 4'b0000; bus.req_addr[1*8 +: 8] = 8'hFF;
    tick();
    chk("t5_addr_busy", bus.rtc_addr, 8'h44);
    chk("t5_gnt", bus.gnt, 4'b0010);
    tick();
    bus.rtc_done = 1'b1; bus.rtc_rdata = 8'h77;
    tick();
    bus.rtc_done = 1'b0;
    chk("t5_ack", bus.ack, 4'b0010);
    chk("t5_addr_rel", bus.rtc_addr, 8'h44);
    chk("t5_rdata", bus.rdata, 8'h77);
    tick();
    // no done: timeout when enabled, otherwise BUSY holds
    bus.req = 4'b0100; bus.req_rnw[2] = 1'b0;
    tick();
    bus.req = 4'b0000;
    tick();
`ifdef RTC_ARB_TIMEOUT_EN
    for (int k = 1; k < 8; k++) begin
      tick();
      chk("t6_wait_ack", bus.ack, 0);
      chk("t6_wait_err", bus.err, 0);
    end
    tick();
    chk("t6_to_ack", bus.ack, 4'b0100);
    chk("t6_to_err", bus.err, 1);
    chk("t6_to_rdata", bus.rdata, 8'h77);
    tick();
    chk("t6_err_clr", bus.err, 0);
    chk("t6_idle", bus.busy, 0);
`else
    for (int k = 0; k < 20; k++) tick();
    chk("t6_hold_busy", bus.busy, 1);
    chk("t6_hold_gnt", bus.gnt, 4'b0100);
    chk("t6_hold_ack", bus.ack, 0);
    chk("t6_hold_err", bus.err, 0);
    bus.rtc_done = 1'b1;
    tick();
    bus.rtc_done = 1'b0;
    chk("t6_late_ack", bus.ack, 4'b0100);
    tick();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
